// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// states, ALU codes, opcodes, functs and mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_LD   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EX_R    = 4'd6,
    S_WB_R    = 4'd7,
    S_EX_I    = 4'd8,
    S_WB_I    = 4'd9,
    S_BR      = 4'd10,
    S_JMP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CL_IDLE,
    CL_ADDU,
    CL_R,
    CL_I,
    CL_BR
  } cls_t;

  localparam logic [5:0] ALU_ADD  = 6'b000001;
  localparam logic [5:0] ALU_ADDU = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000011;
  localparam logic [5:0] ALU_SUBU = 6'b000010;
  localparam logic [5:0] ALU_AND  = 6'b000100;
  localparam logic [5:0] ALU_OR   = 6'b000110;
  localparam logic [5:0] ALU_XOR  = 6'b001000;
  localparam logic [5:0] ALU_NOR  = 6'b001010;
  localparam logic [5:0] ALU_SLL  = 6'b001100;
  localparam logic [5:0] ALU_SRL  = 6'b001110;
  localparam logic [5:0] ALU_SRA  = 6'b010000;
  localparam logic [5:0] ALU_SLT  = 6'b010011;
  localparam logic [5:0] ALU_SLTU = 6'b010101;
  localparam logic [5:0] ALU_BCMP = 6'b010111;
  localparam logic [5:0] ALU_LUI  = 6'b011000;
  localparam logic [5:0] ALU_IDLE = 6'b111111;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_RS    = 2'b01;
  localparam logic [1:0] A_SHAMT = 2'b10;

  localparam logic [1:0] B_RT     = 2'b00;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMMSL2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU code decode from state class, opcode and funct,
// plus shift detection and instruction legality.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  cls_t       cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_code,
  output logic       is_shift,
  output logic       legal
);

  logic [5:0] r_code;
  logic       r_legal;
  logic [5:0] i_code;

  // Decode R-type funct, I-type opcode and overall legality
  always_comb begin
    r_code  = ALU_IDLE;
    r_legal = 1'b1;
    case (funct)
      F_ADD:   r_code = ALU_ADD;
      F_ADDU:  r_code = ALU_ADDU;
      F_SUB:   r_code = ALU_SUB;
      F_SUBU:  r_code = ALU_SUBU;
      F_AND:   r_code = ALU_AND;
      F_OR:    r_code = ALU_OR;
      F_XOR:   r_code = ALU_XOR;
      F_NOR:   r_code = ALU_NOR;
      F_SLL:   r_code = ALU_SLL;
      F_SRL:   r_code = ALU_SRL;
      F_SRA:   r_code = ALU_SRA;
      F_SLT:   r_code = ALU_SLT;
      F_SLTU:  r_code = ALU_SLTU;
      F_JR:    r_code = ALU_IDLE;
      default: r_legal = 1'b0;
    endcase

    i_code = ALU_IDLE;
    case (opcode)
      OP_ADDI:  i_code = ALU_ADD;
      OP_ADDIU: i_code = ALU_ADDU;
      OP_ANDI:  i_code = ALU_AND;
      OP_ORI:   i_code = ALU_OR;
      OP_SLTI:  i_code = ALU_SLT;
      OP_SLTIU: i_code = ALU_SLTU;
      OP_LUI:   i_code = ALU_LUI;
      default:  i_code = ALU_IDLE;
    endcase

    case (opcode)
      OP_R:     legal = r_legal;
      OP_J,
      OP_JAL,
      OP_BEQ,
      OP_BNE,
      OP_LW,
      OP_SW,
      OP_ADDI,
      OP_ADDIU,
      OP_ANDI,
      OP_ORI,
      OP_SLTI,
      OP_SLTIU,
      OP_LUI:   legal = 1'b1;
      default:  legal = 1'b0;
    endcase

    is_shift = (opcode == OP_R) &&
               (funct == F_SLL || funct == F_SRL ||
                funct == F_SRA);

    case (cls)
      CL_ADDU: alu_code = ALU_ADDU;
      CL_R:    alu_code = r_code;
      CL_I:    alu_code = i_code;
      CL_BR:   alu_code = ALU_BCMP;
      default: alu_code = ALU_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath:
// sequences IF/ID/EX/MEM/WB and drives mux selects and strobes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int         STATE_W    = 4,
  parameter logic [1:0] PC_INC_SEL = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               ExtOp,
  output logic [4:0]         ALUCtrl,
  output logic               Sign,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     st, nxt;
  logic [1:0] sub, sub_nxt;
  cls_t       cls;
  logic [5:0] alu_code;
  logic       is_shift;
  logic       legal;

  // sub remembers which variant was decoded in ID:
  // MEM 0=lw 1=sw, BR 0=beq 1=bne, JMP 0=j 1=jal 2=jr
  logic is_mem, is_r, is_br, is_jmp, is_jr;

  assign is_jr  = (opcode == OP_R) && (funct == F_JR);
  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_r   = (opcode == OP_R) && !is_jr;
  assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_jmp = (opcode == OP_J) || (opcode == OP_JAL) || is_jr;

  alu_op_decode u_dec (
    .cls      (cls),
    .opcode   (opcode),
    .funct    (funct),
    .alu_code (alu_code),
    .is_shift (is_shift),
    .legal    (legal)
  );

  assign state   = st;
  assign ALUCtrl = alu_code[5:1];
  assign Sign    = alu_code[0];

  // State and decoded-variant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_IF;
      sub <= 2'd0;
    end else begin
      st  <= nxt;
      sub <= sub_nxt;
    end
  end

  // Next-state and variant capture
  always_comb begin
    nxt     = S_IF;
    sub_nxt = sub;
    case (st)
      S_IF: nxt = S_ID;
      S_ID: begin
        if (!legal) begin
          nxt = S_IF;
        end else begin
          unique case (1'b1)
            is_mem: begin
              nxt     = S_MEM_ADR;
              sub_nxt = (opcode == OP_SW) ? 2'd1 : 2'd0;
            end
            is_r:   nxt = S_EX_R;
            is_br: begin
              nxt     = S_BR;
              sub_nxt = (opcode == OP_BNE) ? 2'd1 : 2'd0;
            end
            is_jmp: begin
              nxt     = S_JMP;
              sub_nxt = is_jr ? 2'd2 :
                        (opcode == OP_JAL) ? 2'd1 : 2'd0;
            end
            default: nxt = S_EX_I;
          endcase
        end
      end
      S_MEM_ADR: nxt = sub[0] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  nxt = S_WB_LD;
      S_EX_R:    nxt = S_WB_R;
      S_EX_I:    nxt = S_WB_I;
      default:   nxt = S_IF;
    endcase
  end

  // ALU class selection per state
  always_comb begin
    case (st)
      S_IF, S_ID, S_MEM_ADR: cls = CL_ADDU;
      S_EX_R:                cls = CL_R;
      S_EX_I:                cls = CL_I;
      S_BR:                  cls = CL_BR;
      default:               cls = CL_IDLE;
    endcase
  end

  // Moore output decode with reset masking of strobes
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = DST_RT;
    MemtoReg = WB_ALU;
    ALUSrcA  = A_PC;
    ALUSrcB  = B_RT;
    PCSource = PC_ALU;
    ExtOp    = 1'b0;
    illegal  = 1'b0;
    case (st)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = PC_INC_SEL;
        PCWrite = 1'b1;
      end
      S_ID: begin
        ALUSrcB = B_IMMSL2;
        ExtOp   = 1'b1;
        illegal = !legal;
      end
      S_MEM_ADR: begin
        ALUSrcA = A_RS;
        ALUSrcB = B_IMM;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = WB_MDR;
      end
      S_EX_R: ALUSrcA = is_shift ? A_SHAMT : A_RS;
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = DST_RD;
      end
      S_EX_I: begin
        ALUSrcA = A_RS;
        ALUSrcB = B_IMM;
        ExtOp   = !(opcode == OP_ANDI || opcode == OP_ORI ||
                    opcode == OP_LUI);
      end
      S_WB_I: RegWrite = 1'b1;
      S_BR: begin
        ALUSrcA  = A_RS;
        PCSource = PC_ALUOUT;
        PCWrite  = sub[0] ? ~zero : zero;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = (sub == 2'd2) ? PC_RS : PC_JUMP;
        if (sub == 2'd1) begin
          RegWrite = 1'b1;
          RegDst   = DST_RA;
          MemtoReg = WB_PC;
        end
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Each task walks one instruction and checks per-cycle outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic       ExtOp;
  logic [4:0] ALUCtrl;
  logic       Sign;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSource (PCSource),
    .ExtOp    (ExtOp),
    .ALUCtrl  (ALUCtrl),
    .Sign     (Sign),
    .illegal  (illegal),
    .state    (state)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [4:0] strobes;
    reset  = 1'b1;
    zero   = 1'b0;
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    #2;
    strobes = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};
    checks++;
    if (strobes !== 5'b0) begin
      errors++;
      $display("FAIL reset_pre_edge: strobes=%b want 00000", strobes);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      #1;
      strobes = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};
      checks++;
      if (strobes !== 5'b0) begin
        errors++;
        $display("FAIL reset_cyc%0d: strobes=%b want 00000", i, strobes);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state, MemRead, IRWrite, PCWrite, ALUCtrl, Sign, ALUSrcB} !==
        {4'd0, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL reset_first_fetch: st=%0d mr=%b ir=%b pw=%b alu=%b%b srcb=%b",
               state, MemRead, IRWrite, PCWrite, ALUCtrl, Sign, ALUSrcB);
    end
  endtask

  task automatic run_r(input logic [5:0] f, input logic [5:0] code,
                       input logic [1:0] srca);
    opcode = 6'h00;
    funct  = f;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL r_if f=%h: state=%0d want 0", f, state);
    end
    tick();
    checks++;
    if (state !== 4'd1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL r_id f=%h: state=%0d ill=%b want 1 0", f, state, illegal);
    end
    tick();
    checks++;
    if ({state, ALUCtrl, Sign, ALUSrcA, ALUSrcB, RegWrite} !==
        {4'd6, code, srca, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL r_ex f=%h: st=%0d alu=%b%b srca=%b srcb=%b rw=%b want 6 %b %b 00 0",
               f, state, ALUCtrl, Sign, ALUSrcA, ALUSrcB, RegWrite, code, srca);
    end
    tick();
    checks++;
    if ({state, RegWrite, RegDst, MemtoReg, ALUCtrl, Sign} !==
        {4'd7, 1'b1, 2'b01, 2'b00, 6'b111111}) begin
      errors++;
      $display("FAIL r_wb f=%h: st=%0d rw=%b dst=%b m2r=%b alu=%b%b",
               f, state, RegWrite, RegDst, MemtoReg, ALUCtrl, Sign);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL r_back f=%h: state=%0d want 0", f, state);
    end
  endtask

  task automatic test_rtype();
    run_r(6'h22, 6'b000011, 2'b01);
    run_r(6'h2B, 6'b010101, 2'b01);
    run_r(6'h03, 6'b010000, 2'b10);
  endtask

  task automatic test_lw();
    // garbage opcode during IF must not matter
    opcode = 6'h3F;
    funct  = 6'h3F;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL lw_if: state=%0d ill=%b want 0 0", state, illegal);
    end
    tick();
    opcode = 6'h23;
    #1;
    checks++;
    if (state !== 4'd1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL lw_id: state=%0d ill=%b want 1 0", state, illegal);
    end
    tick();
    checks++;
    if ({state, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, Sign} !==
        {4'd2, 2'b01, 2'b10, 1'b1, 6'b000000}) begin
      errors++;
      $display("FAIL lw_adr: st=%0d srca=%b srcb=%b ext=%b alu=%b%b",
               state, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, Sign);
    end
    tick();
    checks++;
    if ({state, MemRead, IorD, MemWrite} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lw_rd: st=%0d mr=%b iord=%b mw=%b want 3 1 1 0",
               state, MemRead, IorD, MemWrite);
    end
    tick();
    checks++;
    if ({state, RegWrite, RegDst, MemtoReg} !==
        {4'd4, 1'b1, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL lw_wb: st=%0d rw=%b dst=%b m2r=%b want 4 1 00 01",
               state, RegWrite, RegDst, MemtoReg);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL lw_back: state=%0d want 0", state);
    end
  endtask

  task automatic run_br(input logic [5:0] op, input logic z,
                        input logic exp_pw);
    opcode = op;
    funct  = 6'h00;
    zero   = z;
    tick();
    tick();
    checks++;
    if ({state, PCWrite, PCSource, ALUCtrl, Sign, ALUSrcA, ALUSrcB} !==
        {4'd10, exp_pw, 2'b01, 6'b010111, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL br op=%h z=%b: st=%0d pw=%b pcs=%b alu=%b%b want 10 %b 01 010111",
               op, z, state, PCWrite, PCSource, ALUCtrl, Sign, exp_pw);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL br_back op=%h: state=%0d want 0", op, state);
    end
    zero = 1'b0;
  endtask

  task automatic test_branch();
    run_br(6'h04, 1'b1, 1'b1);
    run_br(6'h04, 1'b0, 1'b0);
    run_br(6'h05, 1'b1, 1'b0);
    run_br(6'h05, 1'b0, 1'b1);
  endtask

  task automatic test_jal();
    opcode = 6'h03;
    tick();
    tick();
    checks++;
    if ({state, PCWrite, PCSource, RegWrite, RegDst, MemtoReg} !==
        {4'd11, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10}) begin
      errors++;
      $display("FAIL jal: st=%0d pw=%b pcs=%b rw=%b dst=%b m2r=%b",
               state, PCWrite, PCSource, RegWrite, RegDst, MemtoReg);
    end
    tick();
  endtask

  task automatic test_illegal();
    opcode = 6'h3F;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_if: illegal=%b want 0", illegal);
    end
    tick();
    checks++;
    if (state !== 4'd1 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL ill_id: state=%0d ill=%b want 1 1", state, illegal);
    end
    tick();
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_after: state=%0d ill=%b want 0 0", state, illegal);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h2B;
    tick();
    tick();
    tick();
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL sw_wr: state=%0d mw=%b want 5 1", state, MemWrite);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL sw_rst_mw: MemWrite=%b want 0", MemWrite);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL sw_rst_state: state=%0d want 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
